// File: rtl/cache_assoc_wb.sv
// N-way set-associative, write-back, write-allocate L1 cache with true LRU.
// One data word per line; misses go through a handshaked backing-memory port.
`timescale 1ns/1ps

module cache_assoc_wb #(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 8,
  parameter int WAYS    = 2,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [INDEX_W-1:0]       req_index,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_hit,
  output logic                     rsp_wback,
  output logic                     rsp_load,
  output logic [WAY_W-1:0]         rsp_way,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int SETS = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    FILL,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [DATA_W-1:0] data_mem  [SETS][WAYS];
  logic [WAY_W-1:0]  age_mem   [SETS][WAYS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];

  logic               cap_write;
  logic [INDEX_W-1:0] cap_index;
  logic [TAG_W-1:0]   cap_tag;
  logic [DATA_W-1:0]  cap_wdata;
  logic [WAY_W-1:0]   vic_way;
  logic               wback_pend;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim;
  logic             victim_dirty;
  logic             install;
  logic             touch;
  logic [WAY_W-1:0] acc_way;
  logic [WAY_W-1:0] acc_age;
  logic [WAY_W-1:0] age_nx [WAYS];

  // Tag match and victim choice for the captured set.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_mem[cap_index][w] && tag_mem[cap_index][w] == cap_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_mem[cap_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_mem[cap_index][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim       = inv_found ? inv_way : lru_way;
    victim_dirty = valid_mem[cap_index][victim] & dirty_mem[cap_index][victim];
  end

  // A write miss installs immediately; a read miss waits for the refill ack.
  assign install = (state == FILL) && (cap_write || mem_ack);
  assign touch   = ((state == LOOKUP) && hit) || install;
  assign acc_way = (state == LOOKUP) ? hit_way : vic_way;

  // Ages younger than the accessed way shift up by one; accessed way becomes 0.
  always_comb begin
    acc_age = age_mem[cap_index][acc_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way)
        age_nx[w] = '0;
      else if (age_mem[cap_index][w] < acc_age)
        age_nx[w] = age_mem[cap_index][w] + 1'b1;
      else
        age_nx[w] = age_mem[cap_index][w];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = LOOKUP;
      LOOKUP: begin
        if (hit)               state_nx = RESP;
        else if (victim_dirty) state_nx = WBACK;
        else                   state_nx = FILL;
      end
      WBACK:   if (mem_ack) state_nx = FILL;
      FILL:    if (install) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory port is purely state-decoded so reset drops mem_req asynchronously.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WBACK) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {tag_mem[cap_index][vic_way], cap_index};
      mem_wdata = data_mem[cap_index][vic_way];
    end else if (state == FILL && !cap_write) begin
      mem_req  = 1'b1;
      mem_addr = {cap_tag, cap_index};
    end
  end

  // NOTE: state and storage use non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cap_write  <= 1'b0;
      cap_index  <= '0;
      cap_tag    <= '0;
      cap_wdata  <= '0;
      vic_way    <= '0;
      wback_pend <= 1'b0;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
      rsp_wback  <= 1'b0;
      rsp_load   <= 1'b0;
      rsp_way    <= '0;
      // NOTE: the whole array is reset: valid/dirty/age must be clean, and tag/data are cleared with them so nothing reads X.
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
          age_mem[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      state <= state_nx;

      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_index <= req_index;
        cap_tag   <= req_tag;
        cap_wdata <= req_wdata;
      end

      if (state == LOOKUP) begin
        if (hit) begin
          rsp_hit   <= 1'b1;
          rsp_wback <= 1'b0;
          rsp_load  <= 1'b0;
          rsp_way   <= hit_way;
          if (cap_write) begin
            data_mem[cap_index][hit_way]  <= cap_wdata;
            dirty_mem[cap_index][hit_way] <= 1'b1;
            rsp_data                      <= cap_wdata;
          end else begin
            rsp_data <= data_mem[cap_index][hit_way];
          end
        end else begin
          vic_way    <= victim;
          wback_pend <= victim_dirty;
        end
      end

      if (install) begin
        tag_mem[cap_index][vic_way]   <= cap_tag;
        data_mem[cap_index][vic_way]  <= cap_write ? cap_wdata : mem_rdata;
        valid_mem[cap_index][vic_way] <= 1'b1;
        dirty_mem[cap_index][vic_way] <= cap_write;
        rsp_data                      <= cap_write ? cap_wdata : mem_rdata;
        rsp_hit                       <= 1'b0;
        rsp_wback                     <= wback_pend;
        rsp_load                      <= !cap_write;
        rsp_way                       <= vic_way;
      end

      if (touch) begin
        for (int w = 0; w < WAYS; w++) age_mem[cap_index][w] <= age_nx[w];
      end
    end
  end

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed scoreboard bench for cache_assoc_wb: a 2-way/4-set instance and a
// 4-way/8-set instance share stimulus; use_b selects which one is exercised.
`timescale 1ns/1ps

module tb_cache_assoc_wb;

  typedef struct packed {
    logic [7:0] data;
    logic       hit;
    logic       wback;
    logic       load;
    logic [1:0] way;
  } rsp_t;

  logic clock;
  logic reset_n;
  logic use_b;
  logic req_valid, req_write, mem_ack;
  logic [2:0] req_index;
  logic [7:0] req_tag, req_wdata, mem_rdata;

  logic a_ready, a_rsp_valid, a_hit, a_wback, a_load, a_way, a_mem_req, a_mem_we;
  logic [7:0] a_rsp_data, a_mem_wdata;
  logic [9:0] a_mem_addr;
  logic b_ready, b_rsp_valid, b_hit, b_wback, b_load, b_mem_req, b_mem_we;
  logic [1:0] b_way;
  logic [7:0] b_rsp_data, b_mem_wdata;
  logic [10:0] b_mem_addr;

  logic o_ready, o_rsp_valid, o_hit, o_wback, o_load, o_mem_req, o_mem_we;
  logic [1:0] o_way;
  logic [7:0] o_rsp_data, o_mem_wdata;
  logic [10:0] o_mem_addr;

  int checks = 0;
  int errors = 0;
  rsp_t sb[$];

  cache_assoc_wb #(.INDEX_W(2), .TAG_W(8), .DATA_W(8), .WAYS(2)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & !use_b), .req_ready(a_ready), .req_write(req_write),
    .req_index(req_index[1:0]), .req_tag(req_tag), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_hit(a_hit),
    .rsp_wback(a_wback), .rsp_load(a_load), .rsp_way(a_way),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_ack(mem_ack & !use_b), .mem_rdata(mem_rdata)
  );

  cache_assoc_wb #(.INDEX_W(3), .TAG_W(8), .DATA_W(8), .WAYS(4)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & use_b), .req_ready(b_ready), .req_write(req_write),
    .req_index(req_index), .req_tag(req_tag), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_hit(b_hit),
    .rsp_wback(b_wback), .rsp_load(b_load), .rsp_way(b_way),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_ack(mem_ack & use_b), .mem_rdata(mem_rdata)
  );

  assign o_ready     = use_b ? b_ready     : a_ready;
  assign o_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_data  = use_b ? b_rsp_data  : a_rsp_data;
  assign o_hit       = use_b ? b_hit       : a_hit;
  assign o_wback     = use_b ? b_wback     : a_wback;
  assign o_load      = use_b ? b_load      : a_load;
  assign o_way       = use_b ? b_way       : {1'b0, a_way};
  assign o_mem_req   = use_b ? b_mem_req   : a_mem_req;
  assign o_mem_we    = use_b ? b_mem_we    : a_mem_we;
  assign o_mem_addr  = use_b ? b_mem_addr  : {1'b0, a_mem_addr};
  assign o_mem_wdata = use_b ? b_mem_wdata : a_mem_wdata;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] addr_a(input logic [7:0] tg, input logic [2:0] idx);
    return {1'b0, tg, idx[1:0]};
  endfunction

  function automatic logic [10:0] addr_b(input logic [7:0] tg, input logic [2:0] idx);
    return {tg, idx};
  endfunction

  function automatic rsp_t mk(input logic [7:0] d, input logic h, input logic wb,
                              input logic ld, input logic [1:0] w);
    rsp_t r;
    r.data = d; r.hit = h; r.wback = wb; r.load = ld; r.way = w;
    return r;
  endfunction

  task automatic check_reset_outputs(input string nm);
    check({nm, "/ready"},     o_ready,     1);
    check({nm, "/rsp_valid"}, o_rsp_valid, 0);
    check({nm, "/mem_req"},   o_mem_req,   0);
    check({nm, "/mem_we"},    o_mem_we,    0);
    check({nm, "/mem_addr"},  o_mem_addr,  0);
    check({nm, "/mem_wdata"}, o_mem_wdata, 0);
    check({nm, "/rsp_data"},  o_rsp_data,  0);
    check({nm, "/rsp_flags"}, {o_hit, o_wback, o_load, o_way}, 0);
  endtask

  // One request: drives it, plays the memory (with optional refill stall),
  // pops the scoreboard on rsp_valid and compares.
  task automatic txn(input string nm, input bit wr, input logic [2:0] idx,
                     input logic [7:0] tg, input logic [7:0] wd, input logic [7:0] rd,
                     input int stall, input int exp_lat,
                     input bit exp_wb, input logic [10:0] wb_addr, input logic [7:0] wb_data,
                     input bit exp_ld, input logic [10:0] ld_addr, input rsp_t exp_rsp);
    int n = 1;
    int ack_at = -1;
    int stall_cnt = 0;
    bit saw_wb = 0;
    bit saw_ld = 0;
    rsp_t e;
    @(negedge clock);
    check({nm, "/ready"}, o_ready, 1);
    req_write = wr; req_index = idx; req_tag = tg; req_wdata = wd; req_valid = 1'b1;
    sb.push_back(exp_rsp);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    while (!o_rsp_valid && n <= 60) begin
      if (o_mem_req && o_mem_we) begin
        if (!saw_wb) begin
          check({nm, "/wb_addr"}, o_mem_addr, wb_addr);
          check({nm, "/wb_data"}, o_mem_wdata, wb_data);
        end
        saw_wb  = 1;
        mem_ack = 1'b1;
      end else if (o_mem_req) begin
        if (!saw_ld) check({nm, "/ld_addr"}, o_mem_addr, ld_addr);
        saw_ld = 1;
        if (stall_cnt < stall) begin
          check({nm, "/stall_addr"}, o_mem_addr, ld_addr);
          check({nm, "/stall_ready"}, o_ready, 0);
          stall_cnt++;
          req_valid = 1'b1; req_write = 1'b1; req_tag = 8'hEE; req_wdata = 8'hEE;
        end else begin
          mem_ack = 1'b1; mem_rdata = rd; ack_at = n; req_valid = 1'b0;
        end
      end
      @(negedge clock);
      mem_ack = 1'b0;
      n++;
    end
    req_valid = 1'b0;
    check({nm, "/rsp_seen"}, o_rsp_valid, 1);
    if (o_rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({nm, "/rsp_data"},  o_rsp_data, e.data);
      check({nm, "/rsp_hit"},   o_hit,      e.hit);
      check({nm, "/rsp_wback"}, o_wback,    e.wback);
      check({nm, "/rsp_load"},  o_load,     e.load);
      check({nm, "/rsp_way"},   o_way,      e.way);
      if (exp_lat > 0) check({nm, "/latency"}, n, exp_lat);
      if (saw_ld) check({nm, "/ack_to_rsp"}, n, ack_at + 1);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    check({nm, "/did_wb"}, saw_wb, exp_wb);
    check({nm, "/did_ld"}, saw_ld, exp_ld);
    @(negedge clock);
    check({nm, "/strobe_1cyc"}, o_rsp_valid, 0);
    check({nm, "/data_hold"}, o_rsp_data, exp_rsp.data);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; use_b = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_index = '0; req_tag = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst_a");
    use_b = 1'b1;
    #1 check_reset_outputs("rst_b");
    use_b = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Read miss, second way, then hit with 2-edge latency.
    txn("s1_rd4",  0, 0, 8'd4, 8'h00, 8'hA5, 0, -1, 0, 0, 0, 1, addr_a(4, 0), mk(8'hA5, 0, 0, 1, 0));
    txn("s1_rd5",  0, 0, 8'd5, 8'h00, 8'h5B, 0, -1, 0, 0, 0, 1, addr_a(5, 0), mk(8'h5B, 0, 0, 1, 1));
    txn("s1_hit4", 0, 0, 8'd4, 8'h00, 8'h00, 0,  2, 0, 0, 0, 0, 0,            mk(8'hA5, 1, 0, 0, 0));

    // Clean eviction of the LRU way, then the evicted tag misses.
    txn("s2_rd6",  0, 0, 8'd6, 8'h00, 8'h66, 0, -1, 0, 0, 0, 1, addr_a(6, 0), mk(8'h66, 0, 0, 1, 1));
    txn("s2_rd5",  0, 0, 8'd5, 8'h00, 8'h55, 0, -1, 0, 0, 0, 1, addr_a(5, 0), mk(8'h55, 0, 0, 1, 0));

    // Write miss, write hit, then a dirty eviction.
    txn("s3_wr07", 1, 1, 8'd0, 8'h07, 8'h00, 0, -1, 0, 0, 0, 0, 0,            mk(8'h07, 0, 0, 0, 0));
    txn("s3_wr09", 1, 1, 8'd0, 8'h09, 8'h00, 0,  2, 0, 0, 0, 0, 0,            mk(8'h09, 1, 0, 0, 0));
    txn("s3_rd1",  0, 1, 8'd1, 8'h00, 8'h11, 0, -1, 0, 0, 0, 1, addr_a(1, 1), mk(8'h11, 0, 0, 1, 1));
    txn("s3_rd2",  0, 1, 8'd2, 8'h00, 8'h22, 0, -1, 1, addr_a(0, 1), 8'h09, 1, addr_a(2, 1),
        mk(8'h22, 0, 1, 1, 0));

    // Refill stalled 5 cycles with a competing request held on the port.
    txn("s4_stall", 0, 2, 8'd7, 8'h00, 8'h77, 5, -1, 0, 0, 0, 1, addr_a(7, 2), mk(8'h77, 0, 0, 1, 0));
    txn("s4_hit",   0, 2, 8'd7, 8'h00, 8'h00, 0,  2, 0, 0, 0, 0, 0,            mk(8'h77, 1, 0, 0, 0));

    // Reset while a dirty victim is being written back.
    txn("s5_w1", 1, 3, 8'd1, 8'h31, 8'h00, 0, -1, 0, 0, 0, 0, 0, mk(8'h31, 0, 0, 0, 0));
    txn("s5_w2", 1, 3, 8'd2, 8'h32, 8'h00, 0, -1, 0, 0, 0, 0, 0, mk(8'h32, 0, 0, 0, 1));
    @(negedge clock);
    req_write = 1'b0; req_index = 3'd3; req_tag = 8'd3; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!o_mem_req && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("s5/wb_req",   o_mem_req,   1);
    check("s5/wb_we",    o_mem_we,    1);
    check("s5/wb_addr",  o_mem_addr,  addr_a(1, 3));
    check("s5/wb_data",  o_mem_wdata, 8'h31);
    #2 reset_n = 1'b0;
    #1;
    check("s5/req_drop",  o_mem_req,   0);
    check("s5/no_rsp",    o_rsp_valid, 0);
    check("s5/ready_rst", o_ready,     1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("s5/no_rsp_hold", o_rsp_valid, 0);
    end
    reset_n = 1'b1;
    txn("s5_after", 0, 3, 8'd2, 8'h00, 8'h42, 0, -1, 0, 0, 0, 1, addr_a(2, 3), mk(8'h42, 0, 0, 1, 0));

    // 4-way instance: fill set 5, touch ways 0/2/3, then way 1 is the victim.
    use_b = 1'b1;
    txn("s6_f10", 0, 5, 8'd10, 8'h00, 8'h8A, 0, -1, 0, 0, 0, 1, addr_b(10, 5), mk(8'h8A, 0, 0, 1, 0));
    txn("s6_f11", 0, 5, 8'd11, 8'h00, 8'h8B, 0, -1, 0, 0, 0, 1, addr_b(11, 5), mk(8'h8B, 0, 0, 1, 1));
    txn("s6_f12", 0, 5, 8'd12, 8'h00, 8'h8C, 0, -1, 0, 0, 0, 1, addr_b(12, 5), mk(8'h8C, 0, 0, 1, 2));
    txn("s6_f13", 0, 5, 8'd13, 8'h00, 8'h8D, 0, -1, 0, 0, 0, 1, addr_b(13, 5), mk(8'h8D, 0, 0, 1, 3));
    txn("s6_t10", 0, 5, 8'd10, 8'h00, 8'h00, 0,  2, 0, 0, 0, 0, 0,             mk(8'h8A, 1, 0, 0, 0));
    txn("s6_t12", 0, 5, 8'd12, 8'h00, 8'h00, 0,  2, 0, 0, 0, 0, 0,             mk(8'h8C, 1, 0, 0, 2));
    txn("s6_t13", 0, 5, 8'd13, 8'h00, 8'h00, 0,  2, 0, 0, 0, 0, 0,             mk(8'h8D, 1, 0, 0, 3));
    txn("s6_f14", 0, 5, 8'd14, 8'h00, 8'h8E, 0, -1, 0, 0, 0, 1, addr_b(14, 5), mk(8'h8E, 0, 0, 1, 1));
    txn("s6_r11", 0, 5, 8'd11, 8'h00, 8'h9B, 0, -1, 0, 0, 0, 1, addr_b(11, 5), mk(8'h9B, 0, 0, 1, 0));

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_assoc_wb.md
Name: cache_assoc_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L1 cache with true LRU replacement.
- Successor to the fixed 2-way, 4-set, single-cycle cache: adds a valid/ready request handshake, a backing-memory port with handshake for write-back and refill, and generic width, set count and way count.
- Sits between the instruction/request driver and main memory. One data word per line.

Parameters:
- INDEX_W, 2, set index width; SETS = 2**INDEX_W.
- TAG_W, 8, tag width.
- DATA_W, 8, data word width.
- WAYS, 2, associativity; legal values 2 or 4. WAY_W = clog2(WAYS).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  cache can accept a request.
- req_write  in  1  mode: 1 = write, 0 = read.
- req_index  in  INDEX_W  set index.
- req_tag  in  TAG_W  tag.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  DATA_W  read data, or the written data on writes.
- rsp_hit  out  1  request hit.
- rsp_wback  out  1  a dirty victim was written back.
- rsp_load  out  1  a line was refilled from memory.
- rsp_way  out  WAY_W  way used (hit way or victim way).
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write-back, 0 = refill read.
- mem_addr  out  TAG_W+INDEX_W  {tag, index}.
- mem_wdata  out  DATA_W  write-back data.
- mem_ack  in  1  memory completes the access on this edge.
- mem_rdata  in  DATA_W  refill data, valid with mem_ack.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; req_ready=1; all other outputs 0.
  - All valid and dirty bits 0; LRU ages of way w = w in every set.
  - Reset asserted mid-operation aborts immediately: mem_req drops asynchronously and no response is issued.
- Handshake and timing:
  - Request accepted on a rising edge with req_valid & req_ready. req_ready = 1 only in IDLE.
  - Request fields are captured at acceptance; inputs are ignored otherwise.
- IDLE: on accept -> LOOKUP.
- LOOKUP (1 cycle):
  - Compare the captured tag against all valid ways of the set.
  - On a hit -> RESP. Hit latency is exactly 2 edges from acceptance to rsp_valid.
  - On a miss, select the victim: the lowest-index invalid way, else the way with age WAYS-1. If the victim is valid and dirty -> WBACK; otherwise -> FILL.
- WBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - Hold these until an edge with mem_ack=1, then -> FILL.
- FILL:
  - Read miss: mem_req=1, mem_we=0, mem_addr={req tag, index}. On the mem_ack edge, install mem_rdata with valid=1 and dirty=0, then -> RESP.
  - Write miss: no memory read. Install req_wdata with valid=1 and dirty=1 in one cycle, then -> RESP.
- Write hit: update data and set dirty=1. Read hit: no change to the line.
- RESP (1 cycle):
  - rsp_valid=1, with rsp_data, rsp_hit, rsp_wback, rsp_load (1 only on a read miss) and rsp_way.
  - Then -> IDLE.
  - Response fields hold their last values between strobes.
- mem_ack may arrive in the first cycle of mem_req. mem_ack is ignored outside WBACK/FILL.
- mem_req deasserts on the edge that samples mem_ack.
- LRU update on every hit or install:
  - The accessed way's age becomes 0.
  - Ways whose age was less than the accessed way's old age increment by 1.
  - Ages in a set always form a permutation of 0..WAYS-1.
- Width rules: mem_addr concatenates tag (MSBs) and index (LSBs). No arithmetic beyond the WAY_W age counters, which never wrap.

Test Plan:
1. Defaults, read miss then hit:
   - Read idx0 tag4 with mem_rdata=0xA5 -> mem_req read addr {4,0}; rsp hit=0 load=1 wback=0 way=0 data=0xA5.
   - Read idx0 tag5 -> way=1, load=1.
   - Read idx0 tag4 -> hit=1 way=0 data=0xA5, 2 edges after accept, no mem_req.
2. Clean eviction: after scenario 1, read idx0 tag6 -> victim way 1 (tag5, LRU), wback=0 load=1. Then read tag5 -> miss.
3. Write hit then dirty eviction:
   - Write idx1 tag0 data 0x07 (miss) -> load=0 wback=0, dirty line.
   - Write idx1 tag0 data 0x09 -> hit=1.
   - Read idx1 tag1, then read idx1 tag2 -> the second read writes back mem_addr {0,1} data 0x09 (wback=1, load=1).
4. Stalled memory: hold mem_ack=0 for 5 cycles in FILL -> mem_req and mem_addr stable, req_ready=0, req_valid ignored. Ack -> rsp_valid exactly 1 edge later.
5. Reset mid-WBACK: drop reset_n while mem_req=1 -> mem_req=0 immediately, no rsp_valid. After release, a previously resident tag misses.
6. WAYS=4, INDEX_W=3:
   - Fill 4 tags into set 5, touch ways 0, 2, 3 -> the 5th tag evicts way 1.
   - Ages remain a permutation throughout.
